lfsr_checker: RTL and testbench

//  Downstream consumer of the 8-bit Galois LFSR generator. Self-synchronises to the

---
 rtl/lfsr_checker.sv | 119 +++++++++++
 tb/tb_lfsr_checker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// PRBS checker for the 8-bit Galois LFSR generator: self-synchronises to the word
// stream, then reports per-word errors and keeps saturating error/word counters.
module lfsr_checker #(
    parameter int              WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS      = 8'h71,
    parameter int              LOCK_CNT   = 4,
    parameter int              UNLOCK_CNT = 4,
    parameter int              CNT_W      = 16
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clr_cnt,
    output logic             o_lock,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_word_cnt
);

    // run is shared between the lock and unlock searches, so size it for the larger
    localparam int RUN_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam logic [RUN_W-1:0] LOCK_R   = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0] UNLOCK_R = RUN_W'(UNLOCK_CNT);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             have_q, have_d;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic             lock_d, err_d;
    logic [CNT_W-1:0] err_cnt_d, word_cnt_d;
    logic             match;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], 1'b0} ^ ({WIDTH{s[WIDTH-1]}} & TAPS);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // The all-zero word is the LFSR lock-up state, so it is never a valid match
    assign match   = have_q && (i_data == exp_q) && (i_data != '0);
    assign run_inc = run_q + RUN_W'(1);

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        have_d     = have_q;
        run_d      = run_q;
        lock_d     = o_lock;
        err_d      = 1'b0;
        err_cnt_d  = o_err_cnt;
        word_cnt_d = o_word_cnt;
        if (i_valid) begin
            case (state_q)
                SEARCH: begin
                    exp_d  = lfsr_next(i_data);
                    have_d = 1'b1;
                    run_d  = match ? run_inc : '0;
                    if (match && run_inc == LOCK_R) begin
                        state_d = LOCKED;
                        run_d   = '0;
                        lock_d  = 1'b1;
                    end
                end
                LOCKED: begin
                    // Free-run the prediction so a bad word cannot corrupt it
                    exp_d      = lfsr_next(exp_q);
                    word_cnt_d = sat_inc(o_word_cnt);
                    if (match) begin
                        run_d = '0;
                    end else begin
                        err_d     = 1'b1;
                        err_cnt_d = sat_inc(o_err_cnt);
                        run_d     = run_inc;
                        if (run_inc == UNLOCK_R) begin
                            state_d = SEARCH;
                            lock_d  = 1'b0;
                            have_d  = 1'b0;
                            run_d   = '0;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
        if (i_clr_cnt) begin
            err_cnt_d  = '0;
            word_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q    <= SEARCH;
            exp_q      <= '0;
            have_q     <= 1'b0;
            run_q      <= '0;
            o_lock     <= 1'b0;
            o_err      <= 1'b0;
            o_err_cnt  <= '0;
            o_word_cnt <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            have_q     <= have_d;
            run_q      <= run_d;
            o_lock     <= lock_d;
            o_err      <= err_d;
            o_err_cnt  <= err_cnt_d;
            o_word_cnt <= word_cnt_d;
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: two instances (default, and a 4-bit counter / long unlock
// variant) on shared stimulus, each tracked by a behavioural model.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        i_rst = 1'b0, i_valid = 1'b0, i_clr_cnt = 1'b0;
    logic [7:0]  i_data = 8'h00;
    logic        lock1, err1, lock2, err2;
    logic [15:0] err_cnt1, word_cnt1;
    logic [3:0]  err_cnt2, word_cnt2;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    lfsr_checker dut1 (
        .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data), .i_clr_cnt(i_clr_cnt),
        .o_lock(lock1), .o_err(err1), .o_err_cnt(err_cnt1), .o_word_cnt(word_cnt1)
    );

    lfsr_checker #(.UNLOCK_CNT(32), .CNT_W(4)) dut2 (
        .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data), .i_clr_cnt(i_clr_cnt),
        .o_lock(lock2), .o_err(err2), .o_err_cnt(err_cnt2), .o_word_cnt(word_cnt2)
    );

    // Reference model: one slot per instance
    int m_locked[2], m_exp[2], m_have[2], m_run[2], m_err[2], m_ec[2], m_wc[2];
    int lock_n[2] = '{4, 4};
    int unl_n[2]  = '{4, 32};
    int cmax[2]   = '{65535, 15};
    int gen;

    function automatic int prbs(int s);
        int n;
        n = (s * 2) % 256;
        if (s >= 128) n = n ^ 'h71;
        return n;
    endfunction

    function automatic void model_step(int id, bit rst, bit v, int d, bit clr);
        bit hit;
        if (rst) begin
            m_locked[id] = 0; m_exp[id] = 0; m_have[id] = 0; m_run[id] = 0;
            m_err[id] = 0; m_ec[id] = 0; m_wc[id] = 0;
            return;
        end
        m_err[id] = 0;
        if (v) begin
            hit = (m_have[id] != 0) && (d == m_exp[id]) && (d != 0);
            if (m_locked[id] == 0) begin
                m_exp[id]  = prbs(d);
                m_have[id] = 1;
                m_run[id]  = hit ? m_run[id] + 1 : 0;
                if (m_run[id] == lock_n[id]) begin
                    m_locked[id] = 1;
                    m_run[id] = 0;
                end
            end else begin
                m_exp[id] = prbs(m_exp[id]);
                if (m_wc[id] < cmax[id]) m_wc[id]++;
                if (hit) m_run[id] = 0;
                else begin
                    m_err[id] = 1;
                    if (m_ec[id] < cmax[id]) m_ec[id]++;
                    m_run[id]++;
                    if (m_run[id] == unl_n[id]) begin
                        m_locked[id] = 0; m_have[id] = 0; m_run[id] = 0;
                    end
                end
            end
        end
        if (clr) begin
            m_ec[id] = 0;
            m_wc[id] = 0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input bit v, input int d, input bit clr, input bit rst);
        i_valid = v; i_data = d[7:0]; i_clr_cnt = clr; i_rst = rst;
        @(posedge clk);
        model_step(0, rst, v, d, clr);
        model_step(1, rst, v, d, clr);
        #1;
        chk("lock1", {31'd0, lock1}, m_locked[0]);
        chk("err1", {31'd0, err1}, m_err[0]);
        chk("err_cnt1", {16'd0, err_cnt1}, m_ec[0]);
        chk("word_cnt1", {16'd0, word_cnt1}, m_wc[0]);
        chk("lock2", {31'd0, lock2}, m_locked[1]);
        chk("err2", {31'd0, err2}, m_err[1]);
        chk("err_cnt2", {28'd0, err_cnt2}, m_ec[1]);
        chk("word_cnt2", {28'd0, word_cnt2}, m_wc[1]);
    endtask

    // Send the next generator word, optionally corrupted by xor mask
    task automatic send(input int mask);
        cyc(1'b1, gen ^ mask, 1'b0, 1'b0);
        gen = prbs(gen);
    endtask

    task automatic idle();
        cyc(1'b0, $urandom_range(0, 255), 1'b0, 1'b0);
    endtask

    initial begin
        int sent;
        // Reset state
        cyc(1'b1, 'hAA, 1'b1, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("rst_lock", {31'd0, lock1}, 0);
        chk("rst_errcnt", {16'd0, err_cnt1}, 0);

        // Lock on AA,25,4A,94,59
        gen = 'hAA;
        for (int i = 0; i < 4; i++) send(0);
        chk("lock_early", {31'd0, lock1}, 0);
        send(0);
        chk("lock_after_59", {31'd0, lock1}, 1);
        chk("lock_no_err", {16'd0, err_cnt1}, 0);
        chk("next_is_b2", gen, 'hB2);

        // Single error then clean word
        send('h01);
        chk("single_err", {31'd0, err1}, 1);
        chk("single_errcnt", {16'd0, err_cnt1}, 1);
        chk("single_lock", {31'd0, lock1}, 1);
        send(0);
        chk("single_resume", {31'd0, err1}, 0);
        for (int i = 0; i < 3; i++) send(0);

        // Loss of lock after 4 consecutive errors, then relock
        cyc(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send(1 << $urandom_range(0, 7));
        chk("unlock_errcnt", {16'd0, err_cnt1}, 4);
        chk("unlock_lock", {31'd0, lock1}, 0);
        chk("unlock_dut2_held", {31'd0, lock2}, 1);
        for (int i = 0; i < 5; i++) send(0);
        chk("relock", {31'd0, lock1}, 1);

        // Reset mid-lock, relock after LOCK_CNT+1 words
        cyc(1'b1, gen, 1'b0, 1'b1);
        chk("midrst_lock", {31'd0, lock1}, 0);
        chk("midrst_wc", {16'd0, word_cnt1}, 0);
        for (int i = 0; i < 4; i++) send(0);
        chk("midrst_early", {31'd0, lock1}, 0);
        send(0);
        chk("midrst_relock", {31'd0, lock1}, 1);

        // Gapped valid stream
        cyc(1'b0, 0, 1'b0, 1'b1);
        gen = 'hAA;
        for (int i = 0; i < 5; i++) begin
            while ($urandom_range(0, 2) == 0) idle();
            send(0);
        end
        chk("gap_lock", {31'd0, lock1}, 1);
        chk("gap_wc0", {16'd0, word_cnt1}, 0);
        sent = 0;
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1) begin send(0); sent++; end
            else idle();
        end
        chk("gap_wc", {16'd0, word_cnt1}, sent);
        chk("gap_errs", {16'd0, err_cnt1}, 0);

        // All-zero stream never locks
        cyc(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1'b1, 0, 1'b0, 1'b0);
        chk("zero_nolock", {31'd0, lock1}, 0);

        // Saturation on the 4-bit instance, then clear coincident with an error
        gen = $urandom_range(1, 255);
        for (int i = 0; i < 5; i++) send(0);
        chk("sat_locked", {31'd0, lock2}, 1);
        for (int i = 0; i < 20; i++) send('h01);
        chk("sat_errcnt", {28'd0, err_cnt2}, 15);
        chk("sat_wc", {28'd0, word_cnt2}, 15);
        chk("sat_still_locked", {31'd0, lock2}, 1);
        cyc(1'b1, gen ^ 'h01, 1'b1, 1'b0);
        gen = prbs(gen);
        chk("clr_wins_err", {28'd0, err_cnt2}, 0);
        chk("clr_wins_wc", {28'd0, word_cnt2}, 0);
        chk("clr_err_pulse", {31'd0, err2}, 1);

        // Random traffic: gaps, corruptions, clears, occasional reset
        cyc(1'b0, 0, 1'b0, 1'b1);
        gen = $urandom_range(1, 255);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) cyc(1'b0, 0, 1'b0, 1'b1);
            else if ($urandom_range(0, 3) == 0) idle();
            else if ($urandom_range(0, 39) == 0) begin
                cyc(1'b1, gen, 1'b1, 1'b0);
                gen = prbs(gen);
            end else if ($urandom_range(0, 11) == 0) send(1 << $urandom_range(0, 7));
            else send(0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
